// File: rtl/soc_eoc_sample_source.sv
// soc/eoc converter stand-in: answers soc requests with queued samples on x/eoc.
// Latency: eoc falls ACK_DELAY edges after soc is sampled high; x/eoc rise together CONV_CYCLES edges after soc is sampled low.
// Backpressure: none on soc; a load into a full FIFO is dropped (overrun) unless a pop frees a slot on the same edge.
//
// Ports:
//   clock, reset                  posedge clock, asynchronous active-high reset
//   soc / eoc / x                 request in, end-of-conversion out, sample out (stable while eoc=1)
//   load / data_in                enqueue one sample per cycle
//   full / empty / count          FIFO occupancy
//   underrun / overrun / protocol_err  sticky status, cleared only by reset

// Circular sample queue. A push into a full queue still lands when a pop
// frees the head slot on the same edge; a pop on an empty queue is ignored.
module soc_eoc_sample_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          dropped
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          pop_ok;
  logic          push_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign dropped  = push && !push_ok;
  assign head_dat = mem[rd_ptr];

  // Storage needs no reset: head_dat is only consumed when the queue is non-empty.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

module soc_eoc_sample_source #(
  parameter int W           = 8,
  parameter int DEPTH       = 4,
  parameter int ACK_DELAY   = 3,
  parameter int CONV_CYCLES = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       soc,
  output logic                       eoc,
  output logic [W-1:0]               x,
  input  logic                       load,
  input  logic [W-1:0]               data_in,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       underrun,
  output logic                       overrun,
  output logic                       protocol_err
);

  localparam int CNT_MAX = (ACK_DELAY > CONV_CYCLES) ? ACK_DELAY : CONV_CYCLES;
  localparam int CNTW    = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK   = 2'd1,
    WAITL = 2'd2,
    CONV  = 2'd3
  } state_t;

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic [W-1:0]    head_dat;
  logic            fifo_pop;
  logic            fifo_dropped;

  // The completing CONV edge is the only point a sample leaves the queue.
  assign fifo_pop = (state == CONV) && (cnt == '0);

  soc_eoc_sample_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (load),
    .push_dat (data_in),
    .pop      (fifo_pop),
    .head_dat (head_dat),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .dropped  (fifo_dropped)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      eoc          <= 1'b1;
      x            <= '0;
      underrun     <= 1'b0;
      overrun      <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      if (fifo_dropped) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          eoc <= 1'b1;
          if (soc) begin
            state <= ACK;
            cnt   <= CNTW'(ACK_DELAY - 1);
          end
        end
        ACK: begin
          // soc is deliberately ignored while the acknowledge delay runs.
          if (cnt == '0) begin
            state <= WAITL;
            eoc   <= 1'b0;
          end else begin
            cnt <= cnt - CNTW'(1);
          end
        end
        WAITL: begin
          // No timeout: the consumer may hold soc high indefinitely.
          if (!soc) begin
            state <= CONV;
            cnt   <= CNTW'(CONV_CYCLES - 1);
          end
        end
        CONV: begin
          // A consumer raising soc mid-conversion is flagged but not acted on.
          if (soc) begin
            protocol_err <= 1'b1;
          end
          if (cnt == '0) begin
            state <= IDLE;
            eoc   <= 1'b1;
            // x and eoc update on the same edge so a consumer never sees a split.
            if (empty) begin
              x        <= '0;
              underrun <= 1'b1;
            end else begin
              x <= head_dat;
            end
          end else begin
            cnt <= cnt - CNTW'(1);
          end
        end
        default: begin
          state <= IDLE;
          eoc   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_soc_eoc_sample_source.sv
module tb_soc_eoc_sample_source;

  localparam int W           = 8;
  localparam int DEPTH       = 4;
  localparam int ACK_DELAY   = 3;
  localparam int CONV_CYCLES = 3;
  localparam int CW          = $clog2(DEPTH + 1);

  logic          clock;
  logic          reset;
  logic          soc;
  logic          eoc;
  logic [W-1:0]  x;
  logic          load;
  logic [W-1:0]  data_in;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          underrun;
  logic          overrun;
  logic          protocol_err;

  soc_eoc_sample_source #(
    .W           (W),
    .DEPTH       (DEPTH),
    .ACK_DELAY   (ACK_DELAY),
    .CONV_CYCLES (CONV_CYCLES)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .soc          (soc),
    .eoc          (eoc),
    .x            (x),
    .load         (load),
    .data_in      (data_in),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .underrun     (underrun),
    .overrun      (overrun),
    .protocol_err (protocol_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model: queue of pending samples plus expected sticky flags.
  logic [W-1:0] q [$];
  logic [W-1:0] exp_x;
  logic         exp_under;
  logic         exp_over;
  logic         exp_perr;
  int           checks = 0;
  int           errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    exp_x     = '0;
    exp_under = 1'b0;
    exp_over  = 1'b0;
    exp_perr  = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, 32'(count), 32'(q.size()));
    check({tag, "_empty"}, 32'(empty), 32'(q.size() == 0));
    check({tag, "_full"}, 32'(full), 32'(q.size() == DEPTH));
    check({tag, "_underrun"}, 32'(underrun), 32'(exp_under));
    check({tag, "_overrun"}, 32'(overrun), 32'(exp_over));
    check({tag, "_perr"}, 32'(protocol_err), 32'(exp_perr));
  endtask

  task automatic load_one(input logic [W-1:0] v);
    load    = 1'b1;
    data_in = v;
    step();
    load = 1'b0;
    if (q.size() < DEPTH) q.push_back(v);
    else exp_over = 1'b1;
    check("load_count", 32'(count), 32'(q.size()));
  endtask

  // One full soc/eoc handshake. hold: extra cycles soc stays high after eoc falls.
  // reassert: pulse soc during conversion. load_end: load v on the completing edge.
  task automatic request(input int hold, input bit reassert, input bit load_end,
                         input logic [W-1:0] v);
    soc = 1'b1;
    for (int i = 0; i < ACK_DELAY; i++) begin
      step();
      check("ack_eoc_hi", 32'(eoc), 32'd1);
    end
    step();
    check("ack_eoc_lo", 32'(eoc), 32'd0);
    for (int i = 0; i < hold; i++) begin
      step();
      check("waitl_eoc", 32'(eoc), 32'd0);
    end
    soc = 1'b0;
    for (int i = 0; i <= CONV_CYCLES; i++) begin
      soc = (reassert && i == 1) ? 1'b1 : 1'b0;
      if (load_end && i == CONV_CYCLES) begin
        load    = 1'b1;
        data_in = v;
      end
      step();
      load = 1'b0;
      if (i < CONV_CYCLES) begin
        check("conv_eoc", 32'(eoc), 32'd0);
        check("conv_x_hold", 32'(x), 32'(exp_x));
      end
    end
    soc = 1'b0;
    // Completion: pop first (if anything queued), then a same-edge load.
    if (reassert) exp_perr = 1'b1;
    if (q.size() > 0) begin
      exp_x = q.pop_front();
    end else begin
      exp_x     = '0;
      exp_under = 1'b1;
    end
    if (load_end) begin
      if (q.size() < DEPTH) q.push_back(v);
      else exp_over = 1'b1;
    end
    check("done_eoc", 32'(eoc), 32'd1);
    check("done_x", 32'(x), 32'(exp_x));
    check_status("done");
  endtask

  initial begin
    logic [W-1:0] v;
    reset   = 1'b1;
    soc     = 1'b0;
    load    = 1'b0;
    data_in = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("rst_eoc", 32'(eoc), 32'd1);
    check("rst_x", 32'(x), 32'd0);
    check_status("rst");
    reset = 1'b0;
    step();
    check("idle_eoc", 32'(eoc), 32'd1);

    // Basic ordering: 5, 15, 5.
    load_one(8'd5);
    load_one(8'd15);
    load_one(8'd5);
    request(0, 1'b0, 1'b0, '0);
    request(1, 1'b0, 1'b0, '0);
    request(2, 1'b0, 1'b0, '0);

    // Consumer drains a batch of three.
    load_one(8'd64);
    load_one(8'd86);
    load_one(8'd36);
    for (int i = 0; i < 3; i++) request(0, 1'b0, 1'b0, '0);
    check("drained_empty", 32'(empty), 32'd1);

    // Overfill: fifth load is dropped; then load on the final pop edge.
    for (int i = 1; i <= 5; i++) load_one(W'(i));
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_overrun", 32'(overrun), 32'd1);
    request(0, 1'b0, 1'b1, 8'd9);
    check("ovf_pop_load_count", 32'(count), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) request(0, 1'b0, 1'b0, '0);

    // Request with nothing queued.
    request(0, 1'b0, 1'b0, '0);
    check("underrun_set", 32'(underrun), 32'd1);

    // soc reasserted mid-conversion.
    load_one(8'd77);
    request(0, 1'b1, 1'b0, '0);

    // Pointer wrap: 10 random triples, random soc hold.
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 3; i++) load_one(W'($urandom_range(0, 255)));
      for (int i = 0; i < 3; i++) request(int'($urandom_range(0, 3)), 1'b0, 1'b0, '0);
    end

    // Reset in the middle of a conversion with a nonzero x and flags set.
    load_one(8'hA5);
    load_one(8'h3C);
    request(0, 1'b0, 1'b0, '0);
    soc = 1'b1;
    repeat (ACK_DELAY + 1) step();
    soc = 1'b0;
    repeat (2) step();
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check("midrst_eoc", 32'(eoc), 32'd1);
    check("midrst_x", 32'(x), 32'd0);
    check_status("midrst");
    step();
    reset = 1'b0;
    step();

    // Full FIFO with a load landing on the pop edge: no overrun.
    for (int i = 0; i < DEPTH; i++) load_one(W'($urandom_range(1, 255)));
    request(0, 1'b0, 1'b1, 8'h42);
    check("fullpop_overrun", 32'(overrun), 32'd0);
    for (int i = 0; i < DEPTH; i++) request(0, 1'b0, 1'b0, '0);

    // Empty FIFO with a load landing on the pop edge: underrun, count becomes 1.
    request(0, 1'b0, 1'b1, 8'h11);
    check("emptypop_count", 32'(count), 32'd1);
    request(0, 1'b0, 1'b0, '0);
    v = 8'h11;
    check("emptypop_x", 32'(x), 32'(v));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
